// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises one 8-byte pulse-channel status frame into
// byte strobes for a downstream uart_tx. Each byte is held for one full
// UART byte time (10 bits plus a guard bit) before the next strobe.
// The frame carries a sequence number and a mod-256 additive checksum.
module uart_frame_tx #(
  parameter logic [13:0] UART_BPS = 14'd9600,
  parameter logic [25:0] CLK_FREQ = 26'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       send_req,
  input  logic       en1,
  input  logic       en2,
  input  logic [6:0] width1,
  input  logic [6:0] width2,
  input  logic [6:0] gap,
  output logic [7:0] pi_data,
  output logic       pi_flag,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BIT_CYC  = int'(CLK_FREQ) / int'(UART_BPS);
  localparam int unsigned BYTE_CYC = 11 * BIT_CYC;
  localparam int unsigned CNT_W    = (BYTE_CYC > 2) ? $clog2(BYTE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYC - 1);

  localparam logic [7:0] FRAME_HDR = 8'h07;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_seq;

  // Frame fields frozen at request time so input changes cannot leak in.
  logic             r_en1;
  logic             r_en2;
  logic [6:0]       r_w1;
  logic [6:0]       r_w2;
  logic [6:0]       r_gap;
  logic [7:0]       r_seq_cap;

  logic [7:0]       w_sum;
  logic [7:0]       w_byte;

  // Additive checksum over B0..B6, carries discarded by the 8-bit width.
  always_comb begin
    w_sum = FRAME_HDR
          + {7'b0, r_en1}
          + {7'b0, r_en2}
          + {1'b0, r_w1}
          + {1'b0, r_w2}
          + {1'b0, r_gap}
          + r_seq_cap;
  end

  // Select the frame byte addressed by the current byte index.
  always_comb begin
    w_byte = '0;
    case (r_idx)
      3'd0:    w_byte = FRAME_HDR;
      3'd1:    w_byte = {7'b0, r_en1};
      3'd2:    w_byte = {7'b0, r_en2};
      3'd3:    w_byte = {1'b0, r_w1};
      3'd4:    w_byte = {1'b0, r_w2};
      3'd5:    w_byte = {1'b0, r_gap};
      3'd6:    w_byte = r_seq_cap;
      default: w_byte = w_sum;
    endcase
  end

  // Frame sequencer: capture, strobe each byte, pace by byte time, finish.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_seq     <= '0;
      r_en1     <= 1'b0;
      r_en2     <= 1'b0;
      r_w1      <= '0;
      r_w2      <= '0;
      r_gap     <= '0;
      r_seq_cap <= '0;
      pi_data   <= '0;
      pi_flag   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          pi_flag <= 1'b0;
          if (send_req) begin
            r_en1     <= en1;
            r_en2     <= en2;
            r_w1      <= width1;
            r_w2      <= width2;
            r_gap     <= gap;
            r_seq_cap <= r_seq;
            r_idx     <= '0;
            busy      <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          pi_data <= w_byte;
          pi_flag <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          pi_flag <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            if (r_idx == 3'd7) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_SEND;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          pi_flag <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_seq   <= r_seq + 8'd1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with BIT_CYC=10, BYTE_CYC=110.
module tb_uart_frame_tx;

  localparam int SPACING = 111;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       send_req;
  logic       en1;
  logic       en2;
  logic [6:0] width1;
  logic [6:0] width2;
  logic [6:0] gap;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       busy;
  logic       done;

  uart_frame_tx #(
    .UART_BPS(14'd10),
    .CLK_FREQ(26'd100)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .send_req (send_req),
    .en1      (en1),
    .en2      (en2),
    .width1   (width1),
    .width2   (width2),
    .gap      (gap),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .busy     (busy),
    .done     (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0] flag_data[$];
  int         flag_cyc[$];
  int         done_cnt;
  int         done_cyc;

  // Record every strobe and done pulse, sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (pi_flag) begin
      flag_data.push_back(pi_data);
      flag_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int req_cyc;

  typedef struct {
    logic             rst;
    logic             e1;
    logic             e2;
    logic [6:0]       w1;
    logic [6:0]       w2;
    logic [6:0]       g;
    logic [0:7][7:0]  exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic clear_mon();
    flag_data.delete();
    flag_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic set_inputs(input logic e1, input logic e2, input logic [6:0] w1,
                            input logic [6:0] w2, input logic [6:0] g);
    en1 = e1; en2 = e2; width1 = w1; width2 = w2; gap = g;
  endtask

  task automatic request();
    tick();
    send_req = 1'b1;
    req_cyc  = cyc;
    tick();
    send_req = 1'b0;
    chk("busy after request", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_cycle(input int target);
    for (int k = 0; k < 5000 && cyc < target; k++) tick();
  endtask

  task automatic finish_frame(input string nm, input logic [0:7][7:0] exp);
    for (int k = 0; k < 2000 && done_cnt == 0; k++) tick();
    for (int k = 0; k < 20; k++) tick();
    chk({nm, " strobes"}, flag_data.size(), 32'd8);
    chk({nm, " done count"}, done_cnt, 32'd1);
    chk({nm, " busy after"}, {31'b0, busy}, 32'd0);
    if (flag_data.size() == 8) begin
      chk({nm, " B0 latency"}, flag_cyc[0] - req_cyc, 32'd2);
      for (int i = 0; i < 8; i++)
        chk($sformatf("%s B%0d", nm, i), {24'b0, flag_data[i]}, {24'b0, exp[i]});
      for (int i = 1; i < 8; i++)
        chk($sformatf("%s gap%0d", nm, i), flag_cyc[i] - flag_cyc[i-1], SPACING);
      chk({nm, " done latency"}, done_cyc - flag_cyc[7], SPACING);
      chk({nm, " pi_data hold"}, {24'b0, pi_data}, {24'b0, exp[7]});
    end
  endtask

  initial begin
    vecs[0] = '{rst:1'b0, e1:1'b1, e2:1'b0, w1:7'd5, w2:7'd3, g:7'd10,
                exp:{8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h00, 8'h1A}};
    vecs[1] = '{rst:1'b0, e1:1'b1, e2:1'b0, w1:7'd5, w2:7'd3, g:7'd10,
                exp:{8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h01, 8'h1B}};
    vecs[2] = '{rst:1'b1, e1:1'b1, e2:1'b1, w1:7'h7F, w2:7'h7F, g:7'h7F,
                exp:{8'h07, 8'h01, 8'h01, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h86}};
    vecs[3] = '{rst:1'b0, e1:1'b0, e2:1'b1, w1:7'h00, w2:7'h40, g:7'h01,
                exp:{8'h07, 8'h00, 8'h01, 8'h00, 8'h40, 8'h01, 8'h01, 8'h4A}};

    sys_rst_n = 1'b0;
    send_req  = 1'b0;
    set_inputs(1'b0, 1'b0, '0, '0, '0);
    clear_mon();
    do_reset();
    chk("reset pi_data", {24'b0, pi_data}, 32'd0);
    chk("reset pi_flag", {31'b0, pi_flag}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rst) do_reset();
      set_inputs(vecs[v].e1, vecs[v].e2, vecs[v].w1, vecs[v].w2, vecs[v].g);
      clear_mon();
      request();
      finish_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Requests while busy, including the DONE cycle, are dropped.
    set_inputs(1'b1, 1'b0, 7'd5, 7'd3, 7'd10);
    clear_mon();
    tick();
    send_req = 1'b1;
    req_cyc  = cyc;
    tick();
    tick();
    send_req = 1'b0;
    wait_cycle(req_cyc + 300);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    wait_cycle(req_cyc + 889);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    finish_frame("busyreq", {8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h02, 8'h1C});
    for (int k = 0; k < 300; k++) tick();
    chk("busyreq no second frame", flag_data.size(), 32'd8);
    chk("busyreq single done", done_cnt, 32'd1);

    // Inputs changed mid-frame must not alter the captured fields.
    clear_mon();
    request();
    for (int k = 0; k < 50 && flag_data.size() == 0; k++) tick();
    width1 = 7'd9;
    finish_frame("midchg", {8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h03, 8'h1D});
    width1 = 7'd5;

    // Sequence number wrap from FF to 00.
    tick();
    force dut.r_seq = 8'hFF;
    tick();
    release dut.r_seq;
    clear_mon();
    request();
    finish_frame("seqFF", {8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'hFF, 8'h19});
    clear_mon();
    request();
    finish_frame("seq00", {8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h00, 8'h1A});

    // Reset during the wait after B3 aborts the frame without bumping seq.
    clear_mon();
    request();
    for (int k = 0; k < 1000 && flag_data.size() < 4; k++) tick();
    for (int k = 0; k < 10; k++) tick();
    sys_rst_n = 1'b0;
    tick();
    chk("abort pi_data", {24'b0, pi_data}, 32'd0);
    chk("abort pi_flag", {31'b0, pi_flag}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    for (int k = 0; k < 500; k++) tick();
    chk("abort no more strobes", flag_data.size(), 32'd4);
    chk("abort no done", done_cnt, 32'd0);
    clear_mon();
    request();
    finish_frame("postabort", {8'h07, 8'h01, 8'h00, 8'h05, 8'h03, 8'h0A, 8'h00, 8'h1A});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
